// File: rtl/synth_tdm.sv
// Time-multiplexed oscillator bank: one sequential pass over all voices per
// sample tick, with per-voice gain and a saturating mix.
module synth_tdm #(
    parameter int BITWIDTH    = 24,
    parameter int FIXED_POINT = 8,
    parameter int NUM_UNITS   = 4,
    parameter int FREQ_WIDTH  = 16,
    parameter int PHASE_WIDTH = 24,
    parameter int AMP_WIDTH   = 8
) (
    input  logic                            ctl_clk,
    input  logic                            ctl_rst,
    input  logic [FREQ_WIDTH*NUM_UNITS-1:0] freq_in,
    input  logic [2*NUM_UNITS-1:0]          wave_type,
    input  logic [AMP_WIDTH*NUM_UNITS-1:0]  amp_in,
    input  logic                            aud_freq,
    output logic [BITWIDTH-1:0]             wave_out,
    output logic                            wave_valid,
    output logic                            busy,
    output logic                            overrun
);

    localparam int IW   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int ACCW = BITWIDTH + $clog2(NUM_UNITS) + 1;
    localparam int PW   = BITWIDTH + AMP_WIDTH + 1;

    localparam logic signed [ACCW-1:0] HMAX =
        {{(ACCW-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
    localparam logic signed [ACCW-1:0] HMIN =
        {{(ACCW-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [IW-1:0]                     idx;
    logic                              flush_cnt;
    logic                              armed;
    logic                              accept;
    logic                              last;

    logic [FREQ_WIDTH*NUM_UNITS-1:0]   freq_s;
    logic [2*NUM_UNITS-1:0]            wave_s;
    logic [AMP_WIDTH*NUM_UNITS-1:0]    amp_s;
    logic [15:0]                       lfsr;
    logic [15:0]                       lfsr_s;
    logic [PHASE_WIDTH-1:0]            phase [NUM_UNITS];

    logic [PHASE_WIDTH-1:0]            cur_phase;
    logic [PHASE_WIDTH-1:0]            step;
    logic [BITWIDTH-1:0]               t;
    logic [BITWIDTH-2:0]               m;
    logic [1:0]                        wsel;
    logic [AMP_WIDTH-1:0]              amp;
    logic [BITWIDTH-1:0]               tri_v;
    logic [BITWIDTH-1:0]               noise;
    logic [BITWIDTH-1:0]               sample;
    logic signed [PW-1:0]              prod_full;

    logic signed [BITWIDTH-1:0]        prod;
    logic                              prod_v;
    logic signed [ACCW-1:0]            acc;
    logic [BITWIDTH-1:0]               sat;

    assign accept = (state == IDLE) && aud_freq && armed;
    assign last   = (idx == IW'(NUM_UNITS - 1));

    // State register
    always_ff @(posedge ctl_clk or posedge ctl_rst) begin
        if (ctl_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last) state_next = FLUSH;
            FLUSH:   if (flush_cnt) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        busy       = (state != IDLE);
        wave_valid = (state == DONE);
    end

    // Waveform generation for the voice issued this cycle
    always_comb begin
        cur_phase = phase[idx];
        step      = PHASE_WIDTH'(freq_s[FREQ_WIDTH*idx +: FREQ_WIDTH]) << FIXED_POINT;
        t         = cur_phase[PHASE_WIDTH-1 -: BITWIDTH];
        m         = t[BITWIDTH-2:0];
        wsel      = wave_s[2*idx +: 2];
        amp       = amp_s[AMP_WIDTH*idx +: AMP_WIDTH];
        tri_v     = t[BITWIDTH-1] ? {~m, 1'b1} : {m, 1'b0};
        noise     = BITWIDTH'(lfsr_s) << (BITWIDTH - 16);
        sample    = '0;
        unique case (wsel)
            2'b00: sample = t[BITWIDTH-1] ? {1'b1, {(BITWIDTH-1){1'b0}}}
                                          : {1'b0, {(BITWIDTH-1){1'b1}}};
            2'b01: sample = {~t[BITWIDTH-1], m};
            2'b10: sample = {~tri_v[BITWIDTH-1], tri_v[BITWIDTH-2:0]};
            2'b11: sample = noise;
            default: sample = '0;
        endcase
        prod_full = $signed({{(AMP_WIDTH+1){sample[BITWIDTH-1]}}, sample})
                  * $signed({{BITWIDTH{1'b0}}, 1'b0, amp});
    end

    always_comb begin
        if (acc > HMAX) begin
            sat = HMAX[BITWIDTH-1:0];
        end else if (acc < HMIN) begin
            sat = HMIN[BITWIDTH-1:0];
        end else begin
            sat = acc[BITWIDTH-1:0];
        end
    end

    // Datapath: snapshot, phase update, gain pipeline and accumulation
    always_ff @(posedge ctl_clk or posedge ctl_rst) begin
        if (ctl_rst) begin
            armed     <= 1'b0;
            idx       <= '0;
            flush_cnt <= 1'b0;
            freq_s    <= '0;
            wave_s    <= '0;
            amp_s     <= '0;
            lfsr      <= 16'hACE1;
            lfsr_s    <= 16'hACE1;
            prod      <= '0;
            prod_v    <= 1'b0;
            acc       <= '0;
            wave_out  <= '0;
            overrun   <= 1'b0;
            for (int i = 0; i < NUM_UNITS; i++) begin
                phase[i] <= '0;
            end
        end else begin
            armed   <= 1'b1;
            overrun <= aud_freq && (state != IDLE);
            prod_v  <= (state == RUN);
            if (accept) begin
                idx    <= '0;
                freq_s <= freq_in;
                wave_s <= wave_type;
                amp_s  <= amp_in;
                lfsr_s <= lfsr;
                lfsr   <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
            end
            if (state == RUN) begin
                idx        <= idx + 1'b1;
                prod       <= prod_full[AMP_WIDTH +: BITWIDTH];
                phase[idx] <= cur_phase + step;
            end
            if (accept) begin
                acc <= '0;
            end else if (prod_v) begin
                acc <= acc + {{(ACCW-BITWIDTH){prod[BITWIDTH-1]}}, prod};
            end
            if (state == FLUSH) begin
                flush_cnt <= ~flush_cnt;
            end else begin
                flush_cnt <= 1'b0;
            end
            if (state == FLUSH && flush_cnt) begin
                wave_out <= sat;
            end
        end
    end

endmodule

// File: tb/tb_synth_tdm.sv
// Bench for synth_tdm: spec vector table, multi-cycle corner sequences and
// randomized ticks against an arithmetic reference model.
module tb_synth_tdm;

    localparam int BW = 24;
    localparam int NU = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   freq;
    logic [7:0]    wave;
    logic [31:0]   amp;
    logic          aud;
    logic [BW-1:0] wave_out;
    logic          wave_valid;
    logic          busy;
    logic          overrun;

    int total = 0;
    int bad   = 0;
    int vcount = 0;

    longint mphase [NU];
    longint mlfsr;

    synth_tdm dut (
        .ctl_clk    (clk),
        .ctl_rst    (rst),
        .freq_in    (freq),
        .wave_type  (wave),
        .amp_in     (amp),
        .aud_freq   (aud),
        .wave_out   (wave_out),
        .wave_valid (wave_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wave_valid) vcount++;

    typedef struct {
        bit          do_rst;
        logic [7:0]  wave;
        logic [63:0] freq;
        logic [31:0] amp;
        longint      exp;
        string       name;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, exp);
        end
    endtask

    function automatic longint floordiv(input longint p, input longint d);
        longint q;
        q = p / d;
        if ((p % d != 0) && (p < 0)) q = q - 1;
        return q;
    endfunction

    function automatic longint model_sample(input int w, input longint ph, input longint lf);
        longint h, t, m, x;
        h = 64'sd1 << (BW - 1);
        t = ph;
        m = t % h;
        case (w)
            0: return (t < h) ? h - 1 : -h;
            1: return t - h;
            2: return (t < h) ? 2 * m - h : ((64'sd1 << BW) - 1 - 2 * m) - h;
            default: begin
                x = lf * (64'sd1 << (BW - 16));
                if (x >= h) x = x - (64'sd1 << BW);
                return x;
            end
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NU; i++) mphase[i] = 0;
        mlfsr = 'hACE1;
    endtask

    task automatic model_tick(output longint exp);
        longint sum, s, h;
        int w, a, f;
        h = 64'sd1 << (BW - 1);
        sum = 0;
        for (int i = 0; i < NU; i++) begin
            w = int'(wave[2*i +: 2]);
            a = int'(amp[8*i +: 8]);
            f = int'(freq[16*i +: 16]);
            s = model_sample(w, mphase[i], mlfsr);
            sum += floordiv(s * a, 256);
            mphase[i] = (mphase[i] + longint'(f) * 256) % (64'sd1 << 24);
        end
        if (mlfsr % 2 == 1) mlfsr = (mlfsr / 2) ^ 'hB400;
        else mlfsr = mlfsr / 2;
        if (sum > h - 1) sum = h - 1;
        if (sum < -h) sum = -h;
        exp = sum;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    task automatic do_tick(output longint got, output int lat);
        @(negedge clk);
        aud = 1'b1;
        @(negedge clk);
        aud = 1'b0;
        lat = 1;
        while (!wave_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        got = longint'($signed(wave_out));
        @(negedge clk);
    endtask

    function automatic vec_t mk(input bit r, input logic [7:0] w, input logic [63:0] f,
                                input logic [31:0] a, input longint e, input string n);
        vec_t v;
        v.do_rst = r;
        v.wave   = w;
        v.freq   = f;
        v.amp    = a;
        v.exp    = e;
        v.name   = n;
        return v;
    endfunction

    initial begin
        longint got, exp;
        int     lat, nv, ov, vc0, vc1, busy8, vbefore;

        vt[0] = mk(1, 8'h00, 64'h0, 32'hFFFF_FFFF, 64'sd8388607, "sq_f0_possat");
        vt[1] = mk(1, 8'h01, 64'h0100, 32'h0000_00FF, -64'sd8355840, "saw_tick1");
        vt[2] = mk(0, 8'h01, 64'h0100, 32'h0000_00FF, -64'sd8290560, "saw_tick2");
        vt[3] = mk(1, 8'h00, 64'h8000_8000_8000_8000, 32'hFFFF_FFFF, 64'sd8388607, "sq8k_tick1");
        vt[4] = mk(0, 8'h00, 64'h8000_8000_8000_8000, 32'hFFFF_FFFF, -64'sd8388608, "sq8k_negsat");
        vt[5] = mk(1, 8'h01, 64'hFFFF, 32'h0000_00FF, -64'sd8355840, "sawmax_tick1");
        vt[6] = mk(0, 8'h01, 64'hFFFF, 32'h0000_00FF, 64'sd8355585, "sawmax_tick2");
        vt[7] = mk(0, 8'h01, 64'hFFFF, 32'h0000_00FF, 64'sd8355330, "sawmax_wrap");
        vt[8] = mk(1, 8'h03, 64'h0, 32'h0000_00FF, -64'sd5426145, "noise_tick1");
        vt[9] = mk(0, 8'h03, 64'h0, 32'h0000_00FF, -64'sd1929840, "noise_e270");

        rst  = 1'b1;
        aud  = 1'b0;
        freq = '0;
        wave = '0;
        amp  = '0;
        repeat (3) @(negedge clk);
        chk("rst_wave_out", longint'(wave_out), 0);
        chk("rst_valid", longint'(wave_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_overrun", longint'(overrun), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of a pass
        amp = 32'hFFFF_FFFF;
        do_tick(got, lat);
        chk("pre_mid_rst", got, 64'sd8388607);
        @(negedge clk);
        aud = 1'b1;
        @(negedge clk);
        aud = 1'b0;
        repeat (2) @(negedge clk);
        vbefore = vcount;
        rst = 1'b1;
        #1;
        chk("midrst_wave_out", longint'(wave_out), 0);
        chk("midrst_busy", longint'(busy), 0);
        chk("midrst_valid", longint'(wave_valid), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("midrst_no_valid", longint'(vcount - vbefore), 0);

        for (int i = 0; i < 10; i++) begin
            if (vt[i].do_rst) do_reset();
            wave = vt[i].wave;
            freq = vt[i].freq;
            amp  = vt[i].amp;
            do_tick(got, lat);
            chk(vt[i].name, got, vt[i].exp);
            chk({vt[i].name, "_lat"}, longint'(lat), 7);
        end

        // Overlapping ticks: 0 accepted, 2 and 7 dropped, 8 accepted
        do_reset();
        nv = 0;
        ov = 0;
        vc0 = -1;
        vc1 = -1;
        busy8 = -1;
        for (int i = 0; i < 26; i++) begin
            aud = (i == 0 || i == 2 || i == 7 || i == 8);
            @(negedge clk);
            if (wave_valid) begin
                if (nv == 0) vc0 = i + 1;
                if (nv == 1) vc1 = i + 1;
                nv++;
            end
            if (overrun) ov++;
            if (i + 1 == 8) busy8 = int'(busy);
        end
        aud = 1'b0;
        chk("ovr_count", longint'(ov), 2);
        chk("ovr_valid_count", longint'(nv), 2);
        chk("ovr_valid1_cycle", longint'(vc0), 7);
        chk("ovr_valid2_cycle", longint'(vc1), 15);
        chk("busy_drop_cycle8", longint'(busy8), 0);

        // Randomized passes against the reference model
        do_reset();
        for (int n = 0; n < 40; n++) begin
            freq = {$urandom, $urandom};
            wave = 8'($urandom);
            amp  = $urandom;
            if (n % 5 == 0) amp[8*(n % NU) +: 8] = 8'h00;
            model_tick(exp);
            do_tick(got, lat);
            chk("rand_sample", got, exp);
            chk("rand_lat", longint'(lat), 7);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
